writeback_queue: RTL and testbench
==================================

// Module: writeback_queue
//
// PURPOSE
// Write-side companion of the 16x16 regfile: buffers register writebacks from the ALU and
// load unit and drives the regfile's single write port (regWrite/writeAddr/writeData).
// Sits between execute/memory and the regfile, so neither producer stalls on port conflicts.
// Two combinational forwarding ports return the youngest still-pending value for a read address.
//
// PARAMETERS
// DATA_W   16  width of register data
// ADDR_W   4   register address width (16 registers)
// DEPTH    4   queue entries; power of two, >= 2
//
// PORTS
// clk          in   1       rising-edge clock
// reset        in   1       asynchronous, active-low reset (0 = in reset)
// mem_valid    in   1       load unit offers a writeback
// mem_addr     in   ADDR_W  destination register
// mem_data     in   DATA_W  load result
// mem_ready    out  1       queue accepts mem writeback this cycle
// alu_valid    in   1       ALU offers a writeback
// alu_addr     in   ADDR_W  destination register
// alu_data     in   DATA_W  ALU result
// alu_ready    out  1       queue accepts ALU writeback this cycle
// wb_en        in   1       regfile write port free this cycle
// regWrite     out  1       write enable to regfile
// writeAddr    out  ADDR_W  write address to regfile
// writeData    out  DATA_W  write data to regfile
// readAddr1/2  in   ADDR_W  regfile read addresses being issued
// fwdHit1/2    out  1       a pending entry targets readAddr1/2
// fwdData1/2   out  DATA_W  youngest pending data for readAddr1/2 (0 on miss)
// pending      out  $clog2(DEPTH)+1  occupancy count
//
// BEHAVIOUR
// - Circular FIFO: head/tail ptrs $clog2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH.
// - Reset (async, reset==0): ptrs, count, entry valid bits -> 0; regWrite=0, writeAddr=0,
//   writeData=0, fwdHit*=0, fwdData*=0, pending=0, mem_ready=alu_ready=0. Entries pending at
//   reset assertion are discarded (never written).
// - Ready: full = (count==DEPTH). mem_ready = reset & !full. alu_ready = reset & !full & !mem_valid.
//   Load unit has fixed priority; ready never depends on wb_en (no same-cycle pop-to-push path).
// - At most one push per edge: mem if mem_valid&mem_ready, else alu if alu_valid&alu_ready.
// - Drain (combinational from head): regWrite = wb_en & (count!=0); writeAddr/writeData = head
//   entry when count!=0, else 0. Pop on the edge where regWrite==1.
// - Latency: entry pushed at edge N drives regWrite on cycle N+1 (written at edge N+1) if it
//   is at head and wb_en=1. Minimum producer-to-regfile latency = 2 edges.
// - Push and pop same edge: count unchanged, both ptrs advance. Pop on empty impossible.
// - Ordering: writes to the regfile occur strictly in push order, including same-address writes.
// - Forwarding: search all valid entries (excluding this cycle's incoming push) for addr==readAddrN;
//   youngest (closest to tail) wins. Entry at head is included even while being popped.
// - No special handling of register 0; the regfile defines its semantics.
//
// STRUCTURE
// - Package wb_pkg: DATA_W/ADDR_W defaults, typedef struct packed {logic [ADDR_W-1:0] addr;
//   logic [DATA_W-1:0] data;} wb_entry_t, typedef for occupancy count.
// - Sub-module wb_fwd_match: given entry array, valid bits, tail ptr and an address, returns
//   hit + youngest data; instantiated twice (read ports 1 and 2).
//
// TESTING
// - Reset: drive reset=0 mid-stream with 3 pending -> all outputs 0 immediately; after release
//   pending=0, regWrite=0, mem_ready=alu_ready=1.
// - Single path: alu push (r3,16'hBEEF), wb_en=1 -> next cycle regWrite=1, writeAddr=3,
//   writeData=BEEF; following cycle pending=0, regWrite=0.
// - Priority: mem (r1,0x1111) and alu (r2,0x2222) valid same cycle -> alu_ready=0, r1 queued
//   first; next cycle r2 accepted; regfile sees r1 then r2.
// - Full/wrap: wb_en=0, push 4 entries -> pending=4, both ready=0; then wb_en=1 with pushes
//   continuing for 8 cycles -> ptrs wrap, writes emerge in exact push order, count never >4.
// - Forwarding: queue (r5,0x0A0A) then (r5,0x0B0B), wb_en=0, readAddr1=5, readAddr2=6 ->
//   fwdHit1=1 fwdData1=0B0B, fwdHit2=0 fwdData2=0; after both drain fwdHit1=0.
// - Simultaneous push/pop at count=2: pending stays 2, writeData is old head, new entry at tail.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : wb_pkg
// Description : Shared defaults and types for the regfile writeback queue.
//               WB_DATA_W / WB_ADDR_W / WB_DEPTH are the default geometry.
//               wb_entry_t is one queued writeback (destination + value).
//               wb_count_t holds the occupancy count 0..WB_DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 4;
    localparam int WB_DEPTH  = 4;
    localparam int WB_CNT_W  = $clog2(WB_DEPTH) + 1;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef logic [WB_CNT_W-1:0] wb_count_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : wb_fwd_match
// Description : Forwarding lookup over the writeback queue storage. Returns
//               whether any valid entry targets i_lookupAddr and, if so, the
//               data of the youngest such entry (0 on miss).
// Ports       : i_entryAddr  - per-slot destination register
//               i_entryData  - per-slot data
//               i_entryValid - per-slot valid bit
//               i_tailPtr    - next free slot (one past the youngest entry)
//               i_lookupAddr - register address being read
//               o_hit        - some valid entry matches
//               o_data       - youngest matching data, 0 on miss
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] i_entryAddr,
    input  logic [DEPTH-1:0][DATA_W-1:0] i_entryData,
    input  logic [DEPTH-1:0]             i_entryValid,
    input  logic [$clog2(DEPTH)-1:0]     i_tailPtr,
    input  logic [ADDR_W-1:0]            i_lookupAddr,
    output logic                         o_hit,
    output logic [DATA_W-1:0]            o_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] w_idx;

    // Walk the slots starting at the tail: the tail slot holds the oldest
    // entry when full, and the slot just before the tail holds the youngest.
    // Later matches overwrite earlier ones, so the youngest match wins.
    // Slots that are free are skipped through their valid bit.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_tailPtr + PTR_W'(k);
            if (i_entryValid[w_idx] && (i_entryAddr[w_idx] == i_lookupAddr)) begin
                o_hit  = 1'b1;
                o_data = i_entryData[w_idx];
            end
        end
    end

endmodule : wb_fwd_match
`default_nettype wire

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : writeback_queue
// Description : Buffers register writebacks from the load unit and the ALU
//               and feeds them, in arrival order, into the regfile's single
//               write port. Two combinational forwarding ports expose the
//               youngest pending value for each regfile read address.
// Ports       : clk, reset (async, active-low)
//               mem_valid/mem_addr/mem_data/mem_ready - load unit writeback
//               alu_valid/alu_addr/alu_data/alu_ready - ALU writeback
//               wb_en                                 - write port free
//               regWrite/writeAddr/writeData          - regfile write port
//               readAddr1/2, fwdHit1/2, fwdData1/2    - forwarding ports
//               pending                               - occupancy count
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_valid,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     wb_en,
    output logic                     regWrite,
    output logic [ADDR_W-1:0]        writeAddr,
    output logic [DATA_W-1:0]        writeData,
    input  logic [ADDR_W-1:0]        readAddr1,
    input  logic [ADDR_W-1:0]        readAddr2,
    output logic                     fwdHit1,
    output logic [DATA_W-1:0]        fwdData1,
    output logic                     fwdHit2,
    output logic [DATA_W-1:0]        fwdData2,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_FULL_COUNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;
    logic [DEPTH-1:0]             r_valid;
    logic [PTR_W-1:0]             r_head;
    logic [PTR_W-1:0]             r_tail;
    logic [CNT_W-1:0]             r_count;

    logic              w_full;
    logic              w_nonEmpty;
    logic              w_pushMem;
    logic              w_pushAlu;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_pushAddr;
    logic [DATA_W-1:0] w_pushData;

    // ------------------------------------------------------------------
    // Acceptance. Ready is a function of occupancy only (never of wb_en),
    // so a full queue refuses a push even on a cycle where it drains.
    // The load unit has fixed priority: ALU is held off whenever mem_valid.
    // ------------------------------------------------------------------
    assign w_full     = (r_count == c_FULL_COUNT);
    assign w_nonEmpty = (r_count != '0);

    assign mem_ready = reset & ~w_full;
    assign alu_ready = reset & ~w_full & ~mem_valid;

    assign w_pushMem  = mem_valid & mem_ready;
    assign w_pushAlu  = alu_valid & alu_ready;
    assign w_push     = w_pushMem | w_pushAlu;
    assign w_pushAddr = w_pushMem ? mem_addr : alu_addr;
    assign w_pushData = w_pushMem ? mem_data : alu_data;

    // ------------------------------------------------------------------
    // Drain port, combinational from the head entry.
    // ------------------------------------------------------------------
    assign regWrite  = wb_en & w_nonEmpty;
    assign writeAddr = w_nonEmpty ? r_addr[r_head] : '0;
    assign writeData = w_nonEmpty ? r_data[r_head] : '0;
    assign w_pop     = regWrite;

    assign pending   = r_count;

    // ------------------------------------------------------------------
    // Storage and pointers. A push and a pop never touch the same slot:
    // that would need head==tail, i.e. empty (no pop) or full (no push).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= w_pushAddr;
                r_data[r_tail]  <= w_pushData;
                r_tail          <= r_tail + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Forwarding. Looks only at registered entries, so a push arriving
    // this cycle is not visible; the head stays visible while popping.
    // ------------------------------------------------------------------
    wb_fwd_match #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fwd1 (
        .i_entryAddr  (r_addr),
        .i_entryData  (r_data),
        .i_entryValid (r_valid),
        .i_tailPtr    (r_tail),
        .i_lookupAddr (readAddr1),
        .o_hit        (fwdHit1),
        .o_data       (fwdData1)
    );

    wb_fwd_match #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fwd2 (
        .i_entryAddr  (r_addr),
        .i_entryData  (r_data),
        .i_entryValid (r_valid),
        .i_tailPtr    (r_tail),
        .i_lookupAddr (readAddr2),
        .o_hit        (fwdHit2),
        .o_data       (fwdData2)
    );

endmodule : writeback_queue
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_queue
// Description : Self-checking bench for writeback_queue. Directed stimulus
//               pushes hand-computed expected regfile writes into a queue; a
//               monitor pops and compares on every regWrite. Occupancy,
//               ready and forwarding outputs are checked at fixed points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_queue;
    import wb_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_valid, alu_valid, wb_en;
    logic [3:0]  mem_addr, alu_addr, readAddr1, readAddr2;
    logic [15:0] mem_data, alu_data;
    logic        mem_ready, alu_ready, regWrite, fwdHit1, fwdHit2;
    logic [3:0]  writeAddr;
    logic [15:0] writeData, fwdData1, fwdData2;
    logic [2:0]  pending;

    int nCompared = 0;
    int nMismatched = 0;
    wb_entry_t expQ[$];

    writeback_queue #(
        .DATA_W (16),
        .ADDR_W (4),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .wb_en     (wb_en),
        .regWrite  (regWrite),
        .writeAddr (writeAddr),
        .writeData (writeData),
        .readAddr1 (readAddr1),
        .readAddr2 (readAddr2),
        .fwdHit1   (fwdHit1),
        .fwdData1  (fwdData1),
        .fwdHit2   (fwdHit2),
        .fwdData2  (fwdData2),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer one writeback on the chosen port and hold it until accepted.
    // Returns 1 ns after the accepting edge with the valid dropped.
    task automatic push(input bit useMem, input logic [3:0] a, input logic [15:0] d,
                        input bit track);
        bit done = 1'b0;
        if (useMem) begin
            mem_valid = 1'b1; mem_addr = a; mem_data = d;
        end else begin
            alu_valid = 1'b1; alu_addr = a; alu_data = d;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (useMem ? mem_ready : alu_ready) begin
                done = 1'b1;
                if (track) expQ.push_back('{addr: a, data: d});
            end
            @(posedge clk); #1;
        end
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        if (!done) check("push_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit empty = 1'b0;
        for (int i = 0; i < 40 && !empty; i++) begin
            @(negedge clk);
            if (pending == 3'd0) empty = 1'b1;
        end
        if (!empty) check("drain_timeout", {29'd0, pending}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: every regfile write must be the next expected one.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (regWrite === 1'b1) begin
                if (expQ.size() == 0) begin
                    check("unexpected_write", {12'd0, writeAddr, writeData}, 32'hFFFF_FFFF);
                end else begin
                    wb_entry_t e;
                    e = expQ.pop_front();
                    check("write_order", {12'd0, writeAddr, writeData},
                          {12'd0, e.addr, e.data});
                end
            end
            check("pending_bound", {31'd0, (pending <= 3'd4)}, 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; wb_en = 1'b0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        readAddr1 = '0; readAddr2 = '0;

        // Power-on reset state
        #2;
        check("rst_regWrite",  regWrite,  0);
        check("rst_pending",   pending,   0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_alu_ready", alu_ready, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("post_rst_mem_ready", mem_ready, 1);
        check("post_rst_alu_ready", alu_ready, 1);
        @(posedge clk); #1;

        // Single ALU writeback, minimum latency
        wb_en = 1'b1;
        push(1'b0, 4'd3, 16'hBEEF, 1'b1);
        @(negedge clk);
        check("single_regWrite",  regWrite,  1);
        check("single_writeAddr", writeAddr, 3);
        check("single_writeData", writeData, 16'hBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        check("single_pending_after", pending,  0);
        check("single_regWrite_after", regWrite, 0);
        @(posedge clk); #1;

        // Load unit priority over ALU
        mem_valid = 1'b1; mem_addr = 4'd1; mem_data = 16'h1111;
        alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 16'h2222;
        @(negedge clk);
        check("prio_mem_ready", mem_ready, 1);
        check("prio_alu_ready", alu_ready, 0);
        expQ.push_back('{addr: 4'd1, data: 16'h1111});
        @(posedge clk); #1 mem_valid = 1'b0;
        @(negedge clk);
        check("prio_alu_ready_next", alu_ready, 1);
        expQ.push_back('{addr: 4'd2, data: 16'h2222});
        @(posedge clk); #1 alu_valid = 1'b0;
        drain();

        // Reset asserted with three entries pending: they are discarded
        wb_en = 1'b0;
        push(1'b0, 4'd7, 16'h7777, 1'b0);
        push(1'b1, 4'd8, 16'h8888, 1'b0);
        push(1'b0, 4'd9, 16'h9999, 1'b0);
        readAddr1 = 4'd8;
        @(negedge clk);
        check("mid_pending3",  pending,  3);
        check("mid_fwdHit1",   fwdHit1,  1);
        check("mid_fwdData1",  fwdData1, 16'h8888);
        #1 reset = 1'b0; wb_en = 1'b1;
        #1;
        check("arst_regWrite",  regWrite,  0);
        check("arst_writeAddr", writeAddr, 0);
        check("arst_writeData", writeData, 0);
        check("arst_pending",   pending,   0);
        check("arst_mem_ready", mem_ready, 0);
        check("arst_alu_ready", alu_ready, 0);
        check("arst_fwdHit1",   fwdHit1,   0);
        check("arst_fwdData1",  fwdData1,  0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rel_pending",   pending,   0);
        check("rel_regWrite",  regWrite,  0);
        check("rel_mem_ready", mem_ready, 1);
        check("rel_alu_ready", alu_ready, 1);
        @(posedge clk); #1 readAddr1 = 4'd0;

        // Fill to full, then drain while pushing to wrap the pointers
        wb_en = 1'b0;
        for (int i = 0; i < 4; i++)
            push(i[0], 4'(i), 16'hA000 + 16'(i), 1'b1);
        @(negedge clk);
        check("full_pending",   pending,   4);
        check("full_mem_ready", mem_ready, 0);
        check("full_alu_ready", alu_ready, 0);
        @(posedge clk); #1 wb_en = 1'b1;
        for (int i = 0; i < 8; i++)
            push(i[0], 4'(i + 4), 16'hB000 + 16'(i), 1'b1);
        drain();

        // Forwarding: youngest same-address entry wins
        wb_en = 1'b0; readAddr1 = 4'd5; readAddr2 = 4'd6;
        push(1'b0, 4'd5, 16'h0A0A, 1'b1);
        push(1'b1, 4'd5, 16'h0B0B, 1'b1);
        @(negedge clk);
        check("fwd_hit1",  fwdHit1,  1);
        check("fwd_data1", fwdData1, 16'h0B0B);
        check("fwd_hit2",  fwdHit2,  0);
        check("fwd_data2", fwdData2, 0);
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 16'h0C0C;
        @(negedge clk);
        check("fwd_incoming_not_seen", fwdHit2, 0);
        check("fwd_push_ready", alu_ready, 1);
        expQ.push_back('{addr: 4'd6, data: 16'h0C0C});
        @(posedge clk); #1 alu_valid = 1'b0;
        @(negedge clk);
        check("fwd_hit2_queued",  fwdHit2,  1);
        check("fwd_data2_queued", fwdData2, 16'h0C0C);
        @(posedge clk); #1 wb_en = 1'b1;
        @(negedge clk);
        check("fwd_data1_pop0A", fwdData1, 16'h0B0B);
        @(posedge clk); #1;
        @(negedge clk);
        check("fwd_hit1_head_popping",  fwdHit1,  1);
        check("fwd_data1_head_popping", fwdData1, 16'h0B0B);
        @(posedge clk); #1;
        @(negedge clk);
        check("fwd_hit1_drained", fwdHit1,  0);
        check("fwd_hit2_head",    fwdHit2,  1);
        check("fwd_data2_head",   fwdData2, 16'h0C0C);
        @(posedge clk); #1;
        @(negedge clk);
        check("fwd_all_drained_pending", pending, 0);
        check("fwd_hit2_drained",        fwdHit2, 0);
        @(posedge clk); #1;

        // Simultaneous push and pop at count 2
        wb_en = 1'b0;
        push(1'b0, 4'd10, 16'h1010, 1'b1);
        push(1'b1, 4'd11, 16'h1111, 1'b1);
        wb_en = 1'b1; readAddr1 = 4'd12;
        alu_valid = 1'b1; alu_addr = 4'd12; alu_data = 16'h1212;
        @(negedge clk);
        check("pp_pending_before", pending,   2);
        check("pp_old_head",       writeData, 16'h1010);
        check("pp_alu_ready",      alu_ready, 1);
        check("pp_fwd_before",     fwdHit1,   0);
        expQ.push_back('{addr: 4'd12, data: 16'h1212});
        @(posedge clk); #1 alu_valid = 1'b0; wb_en = 1'b0;
        @(negedge clk);
        check("pp_pending_after", pending,   2);
        check("pp_new_head_addr", writeAddr, 11);
        check("pp_new_head_data", writeData, 16'h1111);
        check("pp_tail_fwd_hit",  fwdHit1,   1);
        check("pp_tail_fwd_data", fwdData1,  16'h1212);
        @(posedge clk); #1 wb_en = 1'b1;
        drain();

        check("scoreboard_empty", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule : tb_writeback_queue
`default_nettype wire
